// File: rtl/csa_bist_ctrl.sv
// Self-test and spare-cell repair controller for the reconfigurable 7-bit carry-select adder.
// Optional macro CSA_BIST_EARLY_ABORT_EN: stop the sweep as soon as two cells have failed.
module csa_bist_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] test_output,
  output logic        test,
  output logic [3:0]  test_data,
  output logic [2:0]  is,
  output logic [3:0]  ss,
  output logic        busy,
  output logic        done,
  output logic [3:0]  fault_map,
  output logic        repaired,
  output logic        unrepairable
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_CHECK, S_RECONF, S_DONE} state_t;

  localparam logic [2:0] SETTLE_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  // With no settle time a vector goes straight to its compare cycle.
  localparam state_t VEC_ENTRY = (SETTLE > 0) ? S_APPLY : S_CHECK;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  fm_q, fm_d;
  logic [2:0]  is_q, is_d;
  logic [3:0]  ss_q, ss_d;
  logic        rep_q, rep_d;
  logic        unrep_q, unrep_d;
  logic        test_q, test_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [5:0] golden(input logic [3:0] p);
    logic c0_1, c0_0, s0_1, s0_0, tc1_1, tc1_0, ts1_1, ts1_0;
    logic c1_1, c1_0, s1_1, s1_0;
    c0_1  = p[1] ^ p[0];
    c0_0  = ~(p[1] | p[0]);
    s0_1  = ~(p[1] ^ p[0]);
    s0_0  = p[1] ^ p[0];
    tc1_1 = p[3] ^ p[2];
    tc1_0 = ~(p[3] | p[2]);
    ts1_1 = ~(p[3] ^ p[2]);
    ts1_0 = p[3] ^ p[2];
    {c1_1, s1_1} = c0_1 ? {tc1_1, ts1_1} : {tc1_0, ts1_0};
    {c1_0, s1_0} = c0_0 ? {tc1_1, ts1_1} : {tc1_0, ts1_0};
    return {c1_1, c1_0, s1_1, s1_0, s0_1, s0_0};
  endfunction

  function automatic logic [3:0] cell_fail(input logic [3:0] p, input logic [23:0] obs);
    logic [3:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      f[k] = (obs[6*k +: 6] != golden(p));
    end
    return f;
  endfunction

  function automatic logic multi(input logic [3:0] f);
    return |(f & (f - 4'd1));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fm_d    = fm_q;
    is_d    = is_q;
    ss_d    = ss_q;
    rep_d   = rep_q;
    unrep_d = unrep_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = VEC_ENTRY;
          cnt_d   = '0;
          idx_d   = '0;
          fm_d    = '0;
          rep_d   = 1'b0;
          unrep_d = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else                      cnt_d   = cnt_q + 3'd1;
      end
      S_CHECK: begin
        fm_d = fm_q | cell_fail(idx_q, test_output);
        if (idx_q == 4'hF) begin
          state_d = S_RECONF;
`ifdef CSA_BIST_EARLY_ABORT_EN
        end else if (multi(fm_d)) begin
          state_d = S_RECONF;
`endif
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = VEC_ENTRY;
        end
      end
      S_RECONF: begin
        state_d = S_DONE;
        is_d    = '0;
        ss_d    = '0;
        rep_d   = 1'b0;
        unrep_d = 1'b0;
        if (multi(fm_q)) begin
          unrep_d = 1'b1;
        end else if (fm_q != 4'd0) begin
          rep_d = 1'b1;
          // Cells at and above the faulty one shift over towards the spare.
          for (int k = 0; k < 4; k++) begin
            if (fm_q[k]) begin
              ss_d = 4'hF << k;
              is_d = 3'h7 << k;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    test_d = (state_d == S_APPLY) || (state_d == S_CHECK);
    busy_d = (state_d == S_APPLY) || (state_d == S_CHECK) || (state_d == S_RECONF);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      fm_q    <= '0;
      is_q    <= '0;
      ss_q    <= '0;
      rep_q   <= 1'b0;
      unrep_q <= 1'b0;
      test_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fm_q    <= fm_d;
      is_q    <= is_d;
      ss_q    <= ss_d;
      rep_q   <= rep_d;
      unrep_q <= unrep_d;
      test_q  <= test_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign test         = test_q;
  assign test_data    = idx_q;
  assign is           = is_q;
  assign ss           = ss_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault_map    = fm_q;
  assign repaired     = rep_q;
  assign unrepairable = unrep_q;

endmodule

// File: tb/tb_csa_bist_ctrl.sv
// Bench for csa_bist_ctrl: a faultable adder model feeds the controller; results are
// compared against table constants and a pattern-by-pattern reference model.
module tb_csa_bist_ctrl;

  localparam int S = 1;

  typedef struct packed {
    bit        fe;   // force whole slice
    bit [5:0]  fv;
    bit [5:0]  am;   // and mask (stuck-at-0)
    bit [5:0]  om;   // or mask (stuck-at-1)
    bit [5:0]  xm;   // xor mask on selected patterns
    bit [15:0] ps;
  } fault_t;

  typedef struct packed {
    fault_t [3:0] f;
    bit [3:0] fm;
    bit [2:0] is_e;
    bit [3:0] ss_e;
    bit       rep;
    bit       unrep;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] test_output;
  logic        test, busy, done, repaired, unrepairable;
  logic [3:0]  test_data, ss, fault_map;
  logic [2:0]  is;

  fault_t flt [4];
  int total = 0;
  int bad = 0;
  bit [2:0] last_is = '0;
  bit [3:0] last_ss = '0;

  csa_bist_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .test_output(test_output),
    .test(test), .test_data(test_data), .is(is), .ss(ss), .busy(busy),
    .done(done), .fault_map(fault_map), .repaired(repaired),
    .unrepairable(unrepairable)
  );

  always #5 clk = ~clk;

  function automatic bit [5:0] gold(int p);
    int x0, y0, x1, y1, lo_c1, lo_c0, lo_s1, lo_s0, hi_c1, hi_c0, hi_s1, hi_s0;
    int a_c, a_s, b_c, b_s;
    x0 = (p >> 1) & 1; y0 = p & 1; x1 = (p >> 3) & 1; y1 = (p >> 2) & 1;
    lo_c1 = x0 ^ y0; lo_c0 = (x0 + y0 == 0) ? 1 : 0; lo_s1 = 1 - (x0 ^ y0); lo_s0 = x0 ^ y0;
    hi_c1 = x1 ^ y1; hi_c0 = (x1 + y1 == 0) ? 1 : 0; hi_s1 = 1 - (x1 ^ y1); hi_s0 = x1 ^ y1;
    a_c = (lo_c1 == 1) ? hi_c1 : hi_c0;
    a_s = (lo_c1 == 1) ? hi_s1 : hi_s0;
    b_c = (lo_c0 == 1) ? hi_c1 : hi_c0;
    b_s = (lo_c0 == 1) ? hi_s1 : hi_s0;
    return 6'(a_c * 32 + b_c * 16 + a_s * 8 + b_s * 4 + lo_s1 * 2 + lo_s0);
  endfunction

  function automatic bit [5:0] cell_out(int k, int p);
    bit [5:0] v;
    if (flt[k].fe) v = flt[k].fv;
    else           v = (gold(p) & flt[k].am) | flt[k].om;
    if (flt[k].ps[p]) v = v ^ flt[k].xm;
    return v;
  endfunction

  always_comb begin
    test_output = '0;
    for (int k = 0; k < 4; k++) test_output[6*k +: 6] = cell_out(k, int'(test_data));
  end

  function automatic fault_t nofault();
    fault_t f;
    f = '0;
    f.am = 6'h3F;
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the patterns, collect failing cells, derive the repair.
  task automatic model(output bit [3:0] fm, output bit [2:0] ie, output bit [3:0] se,
                       output bit rep, output bit unrep, output int nvec);
    fm = '0; ie = '0; se = '0; rep = 0; unrep = 0; nvec = 16;
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 4; k++) if (cell_out(k, v) != gold(v)) fm[k] = 1'b1;
`ifdef CSA_BIST_EARLY_ABORT_EN
      if ($countones(fm) >= 2) begin nvec = v + 1; break; end
`endif
    end
    if ($countones(fm) >= 2) unrep = 1;
    else if ($countones(fm) == 1) begin
      rep = 1;
      for (int k = 0; k < 4; k++) if (fm[k]) begin
        for (int j = 0; j < 4; j++) se[j] = (j >= k);
        for (int j = 0; j < 3; j++) ie[j] = (j >= k);
      end
    end
  endtask

  // One complete sweep; rs_a/rs_b are cycles in which an extra start is driven (0 = none).
  task automatic sweep(input string tag, input int rs_a, input int rs_b,
                       input bit use_tab, input vec_t tv);
    bit [3:0] fm; bit [2:0] ie; bit [3:0] se; bit rep, unrep;
    int nvec, exp_done, done_cyc, dcnt, tcnt, td_err, cyc;
    model(fm, ie, se, rep, unrep, nvec);
    if (use_tab) begin
      fm = tv.fm; ie = tv.is_e; se = tv.ss_e; rep = tv.rep; unrep = tv.unrep;
    end
    exp_done = nvec * (S + 1) + 2;
    done_cyc = -1; dcnt = 0; tcnt = 0; td_err = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= exp_done + 30) begin
      if (cyc == 1) begin
        chk({tag, " c1 busy"}, busy, 1);
        chk({tag, " c1 test"}, test, 1);
        chk({tag, " c1 flags"}, {fault_map, repaired, unrepairable}, 0);
        chk({tag, " c1 is/ss held"}, {is, ss}, {last_is, last_ss});
      end
      if (test) begin
        tcnt++;
        if (int'(test_data) != (cyc - 1) / (S + 1)) td_err++;
      end
      if (done) begin
        dcnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk({tag, " fault_map"}, fault_map, fm);
          chk({tag, " is"}, is, ie);
          chk({tag, " ss"}, ss, se);
          chk({tag, " repaired"}, repaired, rep);
          chk({tag, " unrepairable"}, unrepairable, unrep);
          chk({tag, " busy at done"}, busy, 0);
        end
      end
      start = (cyc == rs_a || cyc == rs_b) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done cycle"}, done_cyc, exp_done);
    chk({tag, " done pulses"}, dcnt, 1);
    chk({tag, " test cycles"}, tcnt, nvec * (S + 1));
    chk({tag, " test_data seq"}, td_err, 0);
    chk({tag, " idle after"}, {busy, test, is, ss}, {1'b0, 1'b0, ie, se});
    last_is = ie; last_ss = se;
  endtask

  vec_t tab [6];
  vec_t dummy;

  initial begin
    fault_t nf;
    nf = nofault();
    for (int k = 0; k < 4; k++) flt[k] = nf;
    dummy = '0;
    for (int i = 0; i < 6; i++) begin
      tab[i] = '0;
      for (int k = 0; k < 4; k++) tab[i].f[k] = nf;
    end
    // no fault
    tab[0].fm = 4'b0000; tab[0].is_e = 3'b000; tab[0].ss_e = 4'b0000;
    // cell 1 forced to zero
    tab[1].f[1].fe = 1; tab[1].f[1].fv = 6'b000000;
    tab[1].fm = 4'b0010; tab[1].is_e = 3'b110; tab[1].ss_e = 4'b1110; tab[1].rep = 1;
    // cell 3 bit 1 stuck at 0
    tab[2].f[3].am = 6'b111101;
    tab[2].fm = 4'b1000; tab[2].is_e = 3'b000; tab[2].ss_e = 4'b1000; tab[2].rep = 1;
    // cells 0 and 2 corrupted
    tab[3].f[0].fe = 1; tab[3].f[2].fe = 1;
    tab[3].fm = 4'b0101; tab[3].unrep = 1;
    // cell 0 bit 0 flipped on pattern 0xF only
    tab[4].f[0].xm = 6'b000001; tab[4].f[0].ps = 16'h8000;
    tab[4].fm = 4'b0001; tab[4].is_e = 3'b111; tab[4].ss_e = 4'b1111; tab[4].rep = 1;
    // cell 2 bit 5 stuck at 1
    tab[5].f[2].om = 6'b100000;
    tab[5].fm = 4'b0100; tab[5].is_e = 3'b100; tab[5].ss_e = 4'b1100; tab[5].rep = 1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset outputs", {test, test_data, is, ss, busy, done, fault_map, repaired, unrepairable}, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) flt[k] = tab[i].f[k];
      sweep($sformatf("tab%0d", i), 0, 0, 1'b1, tab[i]);
    end

    // reset in the middle of a sweep after a repair left is/ss non-zero
    for (int k = 0; k < 4; k++) flt[k] = tab[1].f[k];
    sweep("pre-rst", 0, 0, 1'b1, tab[1]);
    for (int k = 0; k < 4; k++) flt[k] = nf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("mid-sweep busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst outputs", {test, test_data, is, ss, busy, done, fault_map, repaired, unrepairable}, 0);
    rst = 1'b0;
    last_is = '0; last_ss = '0;
    sweep("post-rst", 0, 0, 1'b1, tab[0]);

    // extra start pulses during the sweep and in the done cycle are ignored
    sweep("restart-ign", 5, 16 * (S + 1) + 2, 1'b1, tab[0]);

    // random faults checked against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        flt[k] = nf;
        if ($urandom_range(0, 2) == 0) begin
          flt[k].xm = 6'($urandom_range(1, 63));
          flt[k].ps = ($urandom_range(0, 1) == 0) ? 16'(1 << $urandom_range(0, 15))
                                                  : 16'($urandom);
        end
      end
      sweep($sformatf("rnd%0d", r), 0, 0, 1'b0, dummy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_bist_ctrl.md
# csa_bist_ctrl

Built-in self-test and repair controller for the reconfigurable 7-bit carry-select adder. It drives the adder's test mode with an exhaustive 4-bit pattern sweep and checks the four observable carry-select cells against an internal golden model. It locates at most one faulty cell, then drives the input (`is`) and output (`ss`) steering selects so the spare cell replaces the faulty one. It sits beside the adder and is its only source of `test`, `test_data`, `is` and `ss`.

## Interface
- `SETTLE`, default 1: cycles each vector is held before the compare cycle; range 0..7.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin self-test; sampled only in IDLE
- `test_output`  in  24  cell outputs from the adder: `{cell3, cell2, cell1, cell0}`, 6 bits each
- `test`  out  1  adder test-mode enable
- `test_data`  out  4  test pattern `{x1, y1, x0, y0}`
- `is`  out  3  adder input-steering selects
- `ss`  out  4  adder output-steering selects
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse when the result is valid
- `fault_map`  out  4  bit k set means cell k failed at least one vector
- `repaired`  out  1  exactly one faulty cell; spare switched in
- `unrepairable`  out  1  two or more faulty cells

## Operation
- States:
  - IDLE: on `start`, go to APPLY. `fault_map`, `repaired` and `unrepairable` clear; the vector index clears to 0.
  - APPLY: `test`=1 and `test_data`=index. Stay for `SETTLE` cycles, then go to CHECK.
  - CHECK: compare each 6-bit slice of `test_output` with the golden value for this index, and OR the mismatches into `fault_map`.
    - If index=15, go to RECONF.
    - Otherwise increment the index and go to APPLY.
  - RECONF: `test`=0. Compute `is`, `ss` and the flags, then go to DONE.
  - DONE: `done`=1, then go to IDLE.
- Golden model for one test-mode cell pair (x, y): `c1`=x^y, `c0`=~(x|y), `s1`=~(x^y), `s0`=x^y.
  - The low pair produces `c0_1`, `c0_0`, `s0_1`, `s0_0`.
  - The high pair produces `tc1_1`, `tc1_0`, `ts1_1`, `ts1_0`.
  - `{c1_1, s1_1}` = `c0_1` ? `{tc1_1, ts1_1}` : `{tc1_0, ts1_0}`.
  - `{c1_0, s1_0}` = `c0_0` ? `{tc1_1, ts1_1}` : `{tc1_0, ts1_0}`.
  - Cell output = `{c1_1, c1_0, s1_1, s1_0, s0_1, s0_0}`.
  - Examples: pattern 0x0 gives 6'b100110; pattern 0xF gives 6'b000010.
- Repair for a single fault in cell k (k = 0..3):
  - `ss` = (4'b1111 << k) & 4'hF.
  - `is` = (3'b111 << k) & 3'h7.
  - `repaired`=1.
- No faults: `is`=000, `ss`=0000, both flags 0.
- Two or more faults: `is`=000, `ss`=0000, `unrepairable`=1.
- The spare cell is not observable through `test_output` and is not tested.
- `is` and `ss` hold their values outside RECONF, so mission-mode steering persists between tests.

## Timing
- Reset values:
  - `test`=0, `test_data`=0, `is`=000, `ss`=0000.
  - `busy`=0, `done`=0, `fault_map`=0, `repaired`=0, `unrepairable`=0.
  - State is IDLE.
- All outputs are registered.
- `start` sampled at edge 0:
  - `busy`=1 and `test`=1 from cycle 1.
  - Each vector occupies `SETTLE`+1 cycles.
  - RECONF occupies cycle 16·(`SETTLE`+1)+1, with `busy` still 1.
  - `done` is high in the following cycle, with `busy`=0.
  - With `SETTLE`=1: vectors in cycles 1–32, RECONF in cycle 33, `done` in cycle 34.
- `fault_map` updates at the end of each CHECK cycle.
- `is`, `ss`, `repaired` and `unrepairable` change only at the end of RECONF.
- `start` while not in IDLE (including DONE) is ignored.
- `rst` asserted mid-sweep returns every output to its reset value at the next edge. This includes dropping `test` and restoring `is`/`ss` to 0.
- `test_data` changes only on APPLY entry.

## Configuration
- `CSA_BIST_EARLY_ABORT_EN` defined: a CHECK that leaves two or more bits set in `fault_map` goes straight to RECONF, skipping the remaining vectors. `done` arrives early and `unrepairable`=1.
- `CSA_BIST_EARLY_ABORT_EN` not defined: all 16 vectors always run, and the latency is fixed as given in Timing.

## Test plan
- Fault-free model, `SETTLE`=1, `start` pulse:
  - `test` high in cycles 1–32.
  - `done` in cycle 34.
  - `fault_map`=0000, `is`=000, `ss`=0000, `repaired`=0.
- Cell 1 slice forced to 6'b000000:
  - Fails on pattern 0x0 (expected 6'b100110).
  - Result: `fault_map`=0010, `is`=110, `ss`=1110, `repaired`=1.
- Cell 3 bit 1 stuck at 0:
  - Fails on pattern 0xF (expected 6'b000010).
  - Result: `fault_map`=1000, `is`=000, `ss`=1000, `repaired`=1.
- Cells 0 and 2 corrupted:
  - `unrepairable`=1, `is`=000, `ss`=0000.
  - With `CSA_BIST_EARLY_ABORT_EN` defined, `done` arrives at the first vector where both cells have failed.
- `rst` in cycle 10 of a sweep:
  - At the next edge, `test`=0, `busy`=0, and `is`/`ss`/flags are 0.
  - A new `start` reruns the full sweep.
- Second `start` pulses in cycles 5 and 34 (DONE):
  - Both ignored.
  - Only one `done` pulse, with no state change.
